// File: rtl/button_cmd_arbiter_if.sv
// Command handshake between the button arbiter (master) and the coprocessor (slave).
interface button_cmd_arbiter_if #(
  parameter int N_BTN = 4
);
  localparam int W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic         op_start;
  logic [W-1:0] op_codigo;
  logic         op_done;

  modport master (output op_start, output op_codigo, input op_done);
  modport slave  (input op_start, input op_codigo, output op_done);
endinterface

// File: rtl/button_cmd_arbiter.sv
// Debounced button press capture with a pending set, arbitrated into one-at-a-time coprocessor commands.
// Grant policy: define ARB_ROUND_ROBIN_EN for round robin, otherwise fixed lowest-index priority.
module button_cmd_arbiter #(
  parameter int N_BTN         = 4,
  parameter int TICK_DIV      = 250000,
  parameter int TIMEOUT_TICKS = 400
) (
  input  logic                 clk_entrada,
  input  logic                 rst_n,
  input  logic [N_BTN-1:0]     botoes_brutos,
  button_cmd_arbiter_if.master cmd,
  output logic                 ocupado,
  output logic                 descartado,
  output logic                 erro_timeout
);
  localparam int W    = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int TC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            r_state;
  logic [TC_W-1:0]   r_tick_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [N_BTN-1:0]  r_s0, r_s1, r_s2;
  logic [N_BTN-1:0]  r_pending;
  logic              r_op_start;
  logic [W-1:0]      r_op_codigo;
  logic              r_ocupado;
  logic              r_descartado;
  logic              r_erro_timeout;
`ifdef ARB_ROUND_ROBIN_EN
  logic [W-1:0]      r_ptr;
`endif

  logic              w_tick;
  logic [N_BTN-1:0]  w_press;
  logic [N_BTN-1:0]  w_clr;
  logic [N_BTN-1:0]  w_drop;
  logic [W-1:0]      w_grant;

  assign w_tick  = (r_tick_cnt == TC_W'(TICK_DIV - 1));
  assign w_press = r_s1 & ~r_s2 & {N_BTN{w_tick}};
  // A re-press landing on the bit being cleared in ISSUE simply re-arms it.
  assign w_drop  = w_press & r_pending & ~w_clr;

  always_comb begin
    w_clr = '0;
    if (r_state == ISSUE) w_clr[r_op_codigo] = 1'b1;
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    for (int k = N_BTN; k >= 1; k--) begin
      idx = (int'(r_ptr) + k) % N_BTN;
      if (r_pending[idx]) w_grant = W'(idx);
    end
  end
`else
  always_comb begin
    w_grant = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (r_pending[k]) w_grant = W'(k);
    end
  end
`endif

  always_ff @(posedge clk_entrada) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_tick_cnt     <= '0;
      r_to_cnt       <= '0;
      r_s0           <= '0;
      r_s1           <= '0;
      r_s2           <= '0;
      r_pending      <= '0;
      r_op_start     <= 1'b0;
      r_op_codigo    <= '0;
      r_ocupado      <= 1'b0;
      r_descartado   <= 1'b0;
      r_erro_timeout <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_ptr          <= W'(N_BTN - 1);
`endif
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) begin
        r_s0 <= botoes_brutos;
        r_s1 <= r_s0;
        r_s2 <= r_s1;
      end
      r_pending    <= (r_pending & ~w_clr) | w_press;
      r_descartado <= |w_drop;
      r_op_start   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (|r_pending) begin
            r_op_start  <= 1'b1;
            r_op_codigo <= w_grant;
            r_ocupado   <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_to_cnt <= '0;
          r_state  <= WAIT;
`ifdef ARB_ROUND_ROBIN_EN
          r_ptr    <= r_op_codigo;
`endif
        end
        WAIT: begin
          // Completion wins over a timeout that lands in the same cycle.
          if (cmd.op_done) begin
            r_ocupado <= 1'b0;
            r_state   <= IDLE;
          end else if (w_tick) begin
            if (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
              r_erro_timeout <= 1'b1;
              r_ocupado      <= 1'b0;
              r_state        <= IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_ocupado <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign cmd.op_start  = r_op_start;
  assign cmd.op_codigo = r_op_codigo;
  assign ocupado       = r_ocupado;
  assign descartado    = r_descartado;
  assign erro_timeout  = r_erro_timeout;
endmodule

// File: doc/button_cmd_arbiter.md
BUTTON_CMD_ARBITER -- requirements
Module: button_cmd_arbiter

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of button requesters (2..8).
REQ-002 SHALL have parameter TICK_DIV, default 250000: clk_entrada cycles per sampling tick.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 400: ticks allowed in WAIT before timeout.
REQ-004 SHALL have port clk_entrada  in  1  system clock; the block uses one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port botoes_brutos  in  N_BTN  raw bouncing buttons, asynchronous to the clock.
REQ-007 SHALL have port op_start  out  1  one-cycle command pulse to the coprocessor.
REQ-008 SHALL have port op_codigo  out  clog2(N_BTN)  index of the granted button; valid while op_start=1 and held until the next grant.
REQ-009 SHALL have port op_done  in  1  coprocessor completion pulse.
REQ-010 SHALL have port ocupado  out  1  high in ISSUE and WAIT.
REQ-011 SHALL have port descartado  out  1  one-cycle pulse when a press is dropped.
REQ-012 SHALL have port erro_timeout  out  1  sticky timeout flag.

Function
REQ-013 SHALL count 0..TICK_DIV-1 and wrap; tick=1 for exactly one cycle when count==TICK_DIV-1.
REQ-014 SHALL keep per button a 3-flop chain s0,s1,s2, shifted only on tick (s0<=raw, s1<=s0, s2<=s1).
REQ-015 SHALL generate press[i] = tick & s1[i] & ~s2[i], evaluated on pre-shift values.
REQ-016 Press latency: raw high sampled at tick k SHALL set pending[i] on the edge ending tick k+2; a press is one event regardless of hold time.
REQ-017 SHALL hold one pending bit per button; press on an already-pending button SHALL leave it set and pulse descartado for one cycle.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-019 IDLE: if any pending, select grant per REQ-030, go to ISSUE next cycle; else stay in IDLE.
REQ-020 ISSUE (exactly one cycle): op_start=1, op_codigo=grant, clear pending[grant], load ptr=grant, go to WAIT.
REQ-021 If press[grant] coincides with its clear in ISSUE, SHALL keep pending[grant] set and SHALL NOT pulse descartado.
REQ-022 WAIT: count ticks; op_done=1 -> IDLE; count reaching TIMEOUT_TICKS without op_done -> erro_timeout=1, IDLE.
REQ-023 op_done and timeout in the same cycle SHALL be treated as completion; erro_timeout unchanged.
REQ-024 op_done outside WAIT (including in ISSUE) SHALL be ignored.
REQ-025 Presses SHALL keep being captured in all states; minimum spacing between two op_start pulses is 2 cycles.

Reset
REQ-026 With rst_n=0 at a clock edge, SHALL clear tick counter, timeout counter, all s0/s1/s2, and pending.
REQ-027 Under reset, SHALL set state=IDLE, ptr=N_BTN-1, and op_start, op_codigo, ocupado, descartado, erro_timeout to 0.
REQ-028 Reset asserted in ISSUE or WAIT SHALL abort the operation with no further op_start.
REQ-029 erro_timeout SHALL be cleared only by reset.

Configuration
REQ-030 SHALL select grant using macro ARB_ROUND_ROBIN_EN: defined -> first pending index searching ptr+1, ptr+2, ... modulo N_BTN; undefined -> lowest pending index (fixed priority) and ptr unused.

Verification (N_BTN=4, TICK_DIV=4, TIMEOUT_TICKS=8)
REQ-031 Press btn2 for 3 ticks, op_done 5 cycles after op_start -> one op_start, op_codigo=2, ocupado high ISSUE..WAIT, back to IDLE.
REQ-032 Toggle btn0 every cycle for 2 ticks, then hold high -> exactly one pending event, no descartado.
REQ-033 pending={0,1,3} after grant 1; ARB_ROUND_ROBIN_EN defined -> order 3,0; undefined -> order 0,3.
REQ-034 Never assert op_done -> erro_timeout=1 after 8 ticks in WAIT, FSM returns to IDLE, flag stays 1 until rst_n=0.
REQ-035 btn1 pending during WAIT, second press of btn1 -> descartado one-cycle pulse, btn1 serviced once.
REQ-036 rst_n=0 mid-WAIT with pending={2} -> all outputs 0 next cycle, no op_start after release until a new press.
